// File: rtl/frac_divider.sv
`default_nettype none
// ============================================================================
// Module      : frac_divider
// Description : Sequential signed fractional divider, Q1.(DATA_WIDTH-1).
//               result = sat(trunc((A * 2^(W-1)) / B)) by restoring division,
//               with a start/done handshake and divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module frac_divider #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done,
    output logic                  busy,
    output logic                  div_zero
);

    localparam int c_NUM_W = 2*DATA_WIDTH-1;
    localparam int c_CNT_W = $clog2(2*DATA_WIDTH);
    // Steps 0..2W-2 perform division; one extra CALC cycle at 2W-1 hands off to FIX.
    localparam logic [c_CNT_W-1:0]    c_CALC_END = c_CNT_W'(2*DATA_WIDTH-1);
    localparam logic [DATA_WIDTH-1:0] c_MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH:0]     r_rem;
    logic [c_NUM_W-1:0]      r_num;
    logic [c_NUM_W-1:0]      r_quo;
    logic [DATA_WIDTH-1:0]   r_absb;
    logic                    r_sign;
    logic                    r_aneg;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_done;
    logic                    r_busy;
    logic                    r_div_zero;

    logic [DATA_WIDTH-1:0]   w_abs_a;
    logic [DATA_WIDTH-1:0]   w_abs_b;
    logic [DATA_WIDTH:0]     w_rem_sh;
    logic                    w_ge;
    logic [DATA_WIDTH:0]     w_rem_next;
    logic                    w_zero;
    logic [DATA_WIDTH-1:0]   w_fix_result;

    // Operand magnitudes; -2^(W-1) maps to 2^(W-1) which still fits unsigned.
    always_comb begin
        w_abs_a = A[DATA_WIDTH-1] ? (~A + DATA_WIDTH'(1)) : A;
        w_abs_b = B[DATA_WIDTH-1] ? (~B + DATA_WIDTH'(1)) : B;
    end

    // One restoring step: shift in the next numerator bit, subtract if it fits.
    // A set remainder MSB means the true shifted value exceeds |B| outright;
    // the modular subtraction still yields the correct (smaller) remainder.
    always_comb begin
        w_rem_sh   = {r_rem[DATA_WIDTH-1:0], r_num[c_NUM_W-1]};
        w_ge       = r_rem[DATA_WIDTH] || (w_rem_sh >= {1'b0, r_absb});
        w_rem_next = w_ge ? (w_rem_sh - {1'b0, r_absb}) : w_rem_sh;
    end

    // Sign restoration and saturation of the unsigned quotient.
    always_comb begin
        w_zero       = (r_absb == '0);
        w_fix_result = '0;
        if (w_zero) begin
            w_fix_result = r_aneg ? c_MIN_NEG : c_MAX_POS;
        end else if (!r_sign) begin
            w_fix_result = (r_quo > c_NUM_W'(c_MAX_POS)) ? c_MAX_POS
                                                         : r_quo[DATA_WIDTH-1:0];
        end else begin
            w_fix_result = (r_quo >= c_NUM_W'(c_MIN_NEG)) ? c_MIN_NEG
                                                          : (~r_quo[DATA_WIDTH-1:0] + DATA_WIDTH'(1));
        end
    end

    // Control FSM and datapath registers; outputs are registered.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_num      <= '0;
            r_quo      <= '0;
            r_absb     <= '0;
            r_sign     <= 1'b0;
            r_aneg     <= 1'b0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_sign  <= A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
                        r_aneg  <= A[DATA_WIDTH-1];
                        r_absb  <= w_abs_b;
                        r_num   <= {w_abs_a, {(DATA_WIDTH-1){1'b0}}};
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (r_cnt == c_CALC_END) begin
                        r_state <= S_FIX;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= {r_quo[c_NUM_W-2:0], w_ge};
                        r_num <= {r_num[c_NUM_W-2:0], 1'b0};
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_FIX: begin
                    r_result   <= w_fix_result;
                    r_div_zero <= w_zero;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_state    <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result   = r_result;
    assign done     = r_done;
    assign busy     = r_busy;
    assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: doc/frac_divider.md
Name: frac_divider

Overview:
- Sequential signed fractional divider. It is the inverse of the datapath's fractional multiply.
- It computes result = A / B in the same signed Q1.(DATA_WIDTH-1) fixed-point format the ALU multiply produces.
- It is multi-cycle with a start/done handshake and sits beside the ALU, so the controller can stall the pipeline on divide instructions.
- Exact quotient: floor-toward-zero of (A * 2^(DATA_WIDTH-1)) / B, then saturated to the signed DATA_WIDTH range.

Parameters:
- DATA_WIDTH, 8: operand and result width in bits; Q1.(DATA_WIDTH-1) signed fractional format.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- nreset  input  1  synchronous, active-low reset.
- start  input  1  request pulse; operands are sampled on the edge where start=1 and busy=0.
- A  input  DATA_WIDTH  signed dividend.
- B  input  DATA_WIDTH  signed divisor.
- result  output  DATA_WIDTH  signed quotient; held stable from done until the next accepted start.
- done  output  1  one-cycle pulse: result and div_zero are valid.
- busy  output  1  high while a division is in progress.
- div_zero  output  1  set with done when B was zero; held with result.

Behaviour:
- Reset (nreset=0 at a rising edge, checked before all else): state=IDLE, result=0, done=0, busy=0, div_zero=0. This applies mid-operation too: the calculation is abandoned and no done is issued.
- States:
  - IDLE: wait for start.
  - CALC: 2*DATA_WIDTH-1 iterations.
  - FIX: sign and saturation.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Accept:
  - In IDLE or DONE with start=1, latch sign = A[msb] XOR B[msb], |A| and |B| as unsigned DATA_WIDTH values (|-2^(W-1)| = 2^(W-1) fits).
  - Load numerator = |A| << (DATA_WIDTH-1) (2*DATA_WIDTH-1 bits) and clear the partial remainder and the iteration counter. Go to CALC, busy=1.
  - start during CALC or FIX is ignored; operands are not re-sampled.
  - start in the DONE cycle is accepted (back-to-back), and done still pulses that cycle.
- CALC:
  - One restoring-division step per cycle, MSB first: shift remainder left by one and bring in the next numerator bit.
  - If remainder >= |B|, subtract |B| and set the quotient bit to 1; otherwise set it to 0.
  - The remainder register is DATA_WIDTH+1 bits.
  - The counter runs 0..2*DATA_WIDTH-2, then goes to FIX.
- FIX:
  - Unsigned quotient Q (2*DATA_WIDTH-1 bits).
  - If |B|=0: div_zero=1; result = 2^(W-1)-1 if A >= 0, else -2^(W-1).
  - Else if sign=0: result = min(Q, 2^(W-1)-1).
  - Else: result = -min(Q, 2^(W-1)).
  - Go to DONE. busy is 1 in CALC and FIX, 0 in IDLE and DONE.
- Latency: start accepted at edge N gives done=1 in the cycle after edge N+2*DATA_WIDTH+1. That is 17 cycles for W=8, fixed for all operands, including divide-by-zero.
- Rounding: truncation toward zero; the remainder is discarded.
- result and div_zero update only in FIX and hold otherwise.

Test Plan:
- Reset: hold nreset=0 two cycles -> result=0x00, done=0, busy=0, div_zero=0. Reset asserted in CALC cycle 5 -> IDLE next edge, no done pulse.
- Basic fractional divides, W=8:
  - A=0x20 (0.25), B=0x40 (0.5) -> result=0x40, div_zero=0.
  - A=0x01, B=0x03 -> 0x2A.
  - Check that done arrives exactly 17 cycles after start and pulses for exactly one cycle.
- Signs and truncation:
  - A=0xE0, B=0x40 -> 0xC0.
  - A=0xFF, B=0x03 -> 0xD6 (-42, toward zero).
  - A=0x20, B=0xC0 -> 0xC0.
  - A=0xE0, B=0xC0 -> 0x40.
- Saturation:
  - A=0x40, B=0x20 -> 0x7F.
  - A=0x80, B=0x80 -> 0x7F.
  - A=0x80, B=0x7F -> 0x80.
  - A=0x80, B=0x01 -> 0x80.
- Divide by zero:
  - A=0x10, B=0x00 -> 0x7F, div_zero=1.
  - A=0xF0, B=0x00 -> 0x80, div_zero=1.
  - A=0x00, B=0x00 -> 0x7F, div_zero=1.
  - All three with normal 17-cycle latency.
- Handshake:
  - start held high throughout -> back-to-back operations every 18 cycles.
  - start pulse with new operands mid-CALC -> ignored; the first result is unchanged.
  - result held stable between done and the next accepted start.
